// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared state encoding and default parameters for the CNN control blocks
package cnn_ctrl_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_WPF = 8;
  localparam int DEF_NUM_F = 8;
  localparam int DEF_MAX_CH = 4;
  localparam int DEF_BASE_OFF = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DONE} fetch_state_e;
endpackage

// File: rtl/kw_addr_calc.sv
// kw_addr_calc: maps (filter slot, channel, word) to a weight ROM address
module kw_addr_calc
  import cnn_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WPF = DEF_WPF,
  parameter int MAX_CH = DEF_MAX_CH,
  parameter int BASE_OFF = DEF_BASE_OFF,
  parameter int FW = 3,
  parameter int CW = 2,
  parameter int WW = 3
) (
  input  logic [FW-1:0]     f_sel_i,
  input  logic [CW-1:0]     ch_idx_i,
  input  logic [WW-1:0]     word_idx_i,
  output logic [ADDR_W-1:0] rom_addr_o
);
  assign rom_addr_o = ADDR_W'(BASE_OFF + (int'(f_sel_i) * MAX_CH + int'(ch_idx_i)) * WPF + int'(word_idx_i));
endmodule

// File: rtl/kw_fetch_seq.sv
// kw_fetch_seq: streams the weight ROM addresses of one filter slot over num_ch channels
module kw_fetch_seq
  import cnn_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WPF = DEF_WPF,
  parameter int NUM_F = DEF_NUM_F,
  parameter int MAX_CH = DEF_MAX_CH,
  parameter int BASE_OFF = DEF_BASE_OFF,
  localparam int FW = NUM_F > 1 ? $clog2(NUM_F) : 1,
  localparam int CW = MAX_CH > 1 ? $clog2(MAX_CH) : 1,
  localparam int NW = $clog2(MAX_CH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_clr,
  input  logic              start,
  input  logic [FW-1:0]     f_sel,
  input  logic [NW-1:0]     num_ch,
  input  logic              ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              addr_valid,
  output logic [CW-1:0]     ch_idx,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  localparam int WW = WPF > 1 ? $clog2(WPF) : 1;
  if (BASE_OFF + NUM_F * MAX_CH * WPF - 1 >= 2 ** ADDR_W) begin : g_rom_overflow
    $error("kw_fetch_seq: weight table does not fit in ADDR_W address bits");
  end
  fetch_state_e state_q, state_d;
  logic [FW-1:0] f_sel_q, f_sel_d;
  logic [NW-1:0] num_ch_q, num_ch_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [WW-1:0] word_q, word_d;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d, calc_addr;
  kw_addr_calc #(
    .ADDR_W(ADDR_W), .WPF(WPF), .MAX_CH(MAX_CH), .BASE_OFF(BASE_OFF),
    .FW(FW), .CW(CW), .WW(WW)
  ) u_calc (
    .f_sel_i(f_sel_d), .ch_idx_i(ch_d), .word_idx_i(word_d), .rom_addr_o(calc_addr)
  );
  // next state: outputs are precomputed so they leave the flops glitch-free
  always_comb begin
    state_d = state_q;
    f_sel_d = f_sel_q;
    num_ch_d = num_ch_q;
    ch_d = ch_q;
    word_d = word_q;
    valid_d = valid_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (soft_clr) begin
      state_d = ST_IDLE;
      ch_d = '0;
      word_d = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          if (num_ch != '0 && num_ch <= NW'(MAX_CH)) begin
            state_d = ST_FETCH;
            f_sel_d = f_sel;
            num_ch_d = num_ch;
            ch_d = '0;
            word_d = '0;
            valid_d = 1'b1;
          end else err_d = 1'b1;
        end
        ST_FETCH: if (ready) begin
          if (last_q) begin
            state_d = ST_DONE;
            ch_d = '0;
            word_d = '0;
            valid_d = 1'b0;
            done_d = 1'b1;
          end else begin
            word_d = word_q == WW'(WPF - 1) ? '0 : word_q + WW'(1);
            ch_d = word_q == WW'(WPF - 1) ? ch_q + CW'(1) : ch_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    last_d = valid_d && NW'(ch_d) == num_ch_d - NW'(1) && word_d == WW'(WPF - 1);
    addr_d = valid_d ? calc_addr : '0;
  end
  // state and registered outputs, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      f_sel_q <= '0;
      num_ch_q <= '0;
      ch_q <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      f_sel_q <= f_sel_d;
      num_ch_q <= num_ch_d;
      ch_q <= ch_d;
      word_q <= word_d;
      valid_q <= valid_d;
      last_q <= last_d;
      done_q <= done_d;
      err_q <= err_d;
      addr_q <= addr_d;
    end
  end
  assign rom_addr = addr_q;
  assign addr_valid = valid_q;
  assign ch_idx = ch_q;
  assign last = last_q;
  assign busy = state_q != ST_IDLE;
  assign done = done_q;
  assign cfg_err = err_q;
endmodule

// File: tb/tb_kw_fetch_seq.sv
// tb_kw_fetch_seq: scoreboard bench for the weight address sequencer
module tb_kw_fetch_seq;
  typedef struct packed {
    logic [9:0] a;
    logic [1:0] c;
    logic       l;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, soft_clr = 1'b0, start = 1'b0, ready = 1'b0;
  logic [2:0] f_sel = '0, num_ch = '0;
  logic [9:0] rom_addr;
  logic [1:0] ch_idx;
  logic addr_valid, last, busy, done, cfg_err;
  int checks = 0, passes = 0, acc = 0;
  logic pend_done = 1'b0;
  exp_t sb[$];
  always #5 clk = ~clk;
  kw_fetch_seq dut (
    .clk(clk), .reset(reset), .soft_clr(soft_clr), .start(start), .f_sel(f_sel),
    .num_ch(num_ch), .ready(ready), .rom_addr(rom_addr), .addr_valid(addr_valid),
    .ch_idx(ch_idx), .last(last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_fetch(input int fs, input int nc);
    for (int c = 0; c < nc; c++)
      for (int w = 0; w < 8; w++)
        sb.push_back('{a: 10'(1 + (fs * 4 + c) * 8 + w), c: 2'(c), l: (c == nc - 1 && w == 7)});
  endtask
  task automatic run_fetch(input int fs, input int nc, input bit poke, input string name);
    int a0, n;
    a0 = acc;
    n = 0;
    ready = 1'b1;
    f_sel = 3'(fs);
    num_ch = 3'(nc);
    start = 1'b1;
    push_fetch(fs, nc);
    tick();
    start = 1'b0;
    while (busy && n < 400) begin
      if (poke && n == 5) begin
        start = 1'b1;
        f_sel = 3'd5;
        num_ch = 3'd1;
      end else start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    chk({name, "_cycles"}, 32'(n), 32'(nc * 8 + 1));
    chk({name, "_words"}, 32'(acc - a0), 32'(nc * 8));
    chk({name, "_sb_left"}, 32'(sb.size()), 0);
  endtask
  task automatic bad_cfg(input int nc, input string name);
    num_ch = 3'(nc);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_err_pulse"}, {29'd0, cfg_err, busy, addr_valid}, 32'b100);
    tick();
    chk({name, "_err_clear"}, {30'd0, cfg_err, busy}, 0);
  endtask
  // monitor: compares every presented word against the scoreboard head
  always @(negedge clk) begin
    if (reset || soft_clr) begin
      sb.delete();
      pend_done = 1'b0;
    end else begin
      if (pend_done) begin
        chk("done_after_last", {30'd0, done, addr_valid}, 32'b10);
        pend_done = 1'b0;
      end else if (done) chk("unexpected_done", 32'(done), 0);
      if (addr_valid) begin
        if (sb.size() == 0) chk("unexpected_word", 32'(rom_addr), 32'h3ff);
        else begin
          chk(ready ? "word" : "held_word", {19'd0, rom_addr, ch_idx, last}, {19'd0, sb[0]});
          if (ready) begin
            if (sb[0].l) pend_done = 1'b1;
            void'(sb.pop_front());
            acc++;
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #12;
    chk("reset_outputs", {17'd0, rom_addr, addr_valid, ch_idx, last, busy, done, cfg_err}, 0);
    reset = 1'b0;
    tick();
    run_fetch(0, 1, 1'b0, "slot0_ch1");
    run_fetch(2, 3, 1'b1, "slot2_ch3");
    f_sel = 3'd1;
    num_ch = 3'd1;
    ready = 1'b1;
    start = 1'b1;
    push_fetch(1, 1);
    tick();
    start = 1'b0;
    tick();
    ready = 1'b0;
    tick();
    tick();
    ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("stall_sb_left", 32'(sb.size()), 0);
    chk("stall_idle", 32'(busy), 0);
    bad_cfg(0, "num_ch0");
    bad_cfg(5, "num_ch5");
    f_sel = 3'd1;
    num_ch = 3'd2;
    start = 1'b1;
    push_fetch(1, 2);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("clr_at_word4", {22'd0, rom_addr}, 32'd36);
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    chk("clr_outputs", {17'd0, rom_addr, addr_valid, ch_idx, last, busy, done, cfg_err}, 0);
    tick();
    chk("clr_sb_flushed", 32'(sb.size()), 0);
    run_fetch(3, 1, 1'b0, "after_clr");
    f_sel = 3'd0;
    num_ch = 3'd2;
    start = 1'b1;
    push_fetch(0, 2);
    tick();
    start = 1'b0;
    tick();
    tick();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {17'd0, rom_addr, addr_valid, ch_idx, last, busy, done, cfg_err}, 0);
    #10;
    reset = 1'b0;
    tick();
    tick();
    chk("post_reset_idle", {30'd0, busy, addr_valid}, 0);
    run_fetch(7, 4, 1'b0, "slot7_ch4");
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
